// File: rtl/mesi_isc_pkg.sv
// Shared encodings and broadcast FIFO entry layout for the MESI coherence interconnect.
package mesi_isc_pkg;

  // Entry fields are sized for the widest supported configuration; the top narrows them.
  localparam int unsigned MaxAddrWidth  = 64;
  localparam int unsigned MaxCpuIdWidth = 8;

  typedef enum logic [2:0] {
    MbusNop     = 3'd0,
    MbusWr      = 3'd1,
    MbusRd      = 3'd2,
    MbusWrBroad = 3'd3,
    MbusRdBroad = 3'd4
  } mbus_cmd_e;

  typedef enum logic [2:0] {
    CbusNop     = 3'd0,
    CbusWrSnoop = 3'd1,
    CbusRdSnoop = 3'd2,
    CbusEnWr    = 3'd3,
    CbusEnRd    = 3'd4
  } cbus_cmd_e;

  typedef enum logic {
    BroadRd = 1'b0,
    BroadWr = 1'b1
  } broad_type_e;

  typedef struct packed {
    logic [MaxAddrWidth-1:0]  addr;
    broad_type_e              btype;
    logic [MaxCpuIdWidth-1:0] cpu_id;
  } fifo_entry_t;

  function automatic cbus_cmd_e snoop_cmd(broad_type_e t);
    return (t == BroadWr) ? CbusWrSnoop : CbusRdSnoop;
  endfunction

  function automatic cbus_cmd_e enable_cmd(broad_type_e t);
    return (t == BroadWr) ? CbusEnWr : CbusEnRd;
  endfunction

endpackage

// File: rtl/mesi_isc_rr_arb.sv
// Round-robin arbiter: search starts one past the last grant, modulo NUM_CPU.
module mesi_isc_rr_arb #(
  parameter int unsigned NUM_CPU      = 4,
  parameter int unsigned CPU_ID_WIDTH = 2
) (
  input  logic [NUM_CPU-1:0]      req,
  input  logic [CPU_ID_WIDTH-1:0] last_grant,
  output logic [NUM_CPU-1:0]      gnt,
  output logic [CPU_ID_WIDTH-1:0] gnt_idx,
  output logic                    gnt_valid
);

  always_comb begin
    int unsigned idx;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_CPU; k++) begin
      idx = (32'(last_grant) + k) % NUM_CPU;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = CPU_ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/mesi_isc_nport.sv
// N-port MESI coherence interconnect: round-robin admission into a broadcast FIFO,
// then snoop every other CPU and enable the originator.
module mesi_isc_nport
  import mesi_isc_pkg::*;
#(
  parameter int unsigned NUM_CPU         = 4,
  parameter int unsigned CPU_ID_WIDTH    = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MBUS_CMD_WIDTH  = 3,
  parameter int unsigned CBUS_CMD_WIDTH  = 3,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CPU*MBUS_CMD_WIDTH-1:0]   mbus_cmd_i,
  input  logic [NUM_CPU*ADDR_WIDTH-1:0]       mbus_addr_i,
  input  logic [NUM_CPU-1:0]                  cbus_ack_i,
  output logic [NUM_CPU-1:0]                  mbus_ack_o,
  output logic [ADDR_WIDTH-1:0]               cbus_addr_o,
  output logic [NUM_CPU*CBUS_CMD_WIDTH-1:0]   cbus_cmd_o,
  output logic [FIFO_DEPTH_LOG2:0]            fifo_count_o
);

  localparam int unsigned CntW = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {StIdle, StSnoop, StEnable} state_e;

  state_e                              state_q, state_d;
  fifo_entry_t                         head_q, head_d, wr_entry;
  fifo_entry_t                         mem [FIFO_DEPTH];
  logic [NUM_CPU-1:0]                  pending_q, pending_d;
  logic [NUM_CPU-1:0]                  req, gnt, mbus_ack_q, mbus_ack_d;
  logic [CPU_ID_WIDTH-1:0]             gnt_idx, last_grant_q, last_grant_d;
  logic [FIFO_DEPTH_LOG2-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]                     count_q, count_d;
  logic [ADDR_WIDTH-1:0]               cbus_addr_q, cbus_addr_d;
  logic [NUM_CPU*CBUS_CMD_WIDTH-1:0]   cbus_cmd_q, cbus_cmd_d;
  logic [MBUS_CMD_WIDTH-1:0]           gnt_cmd;
  logic                                gnt_valid, push, pop;

  for (genvar i = 0; i < NUM_CPU; i++) begin : g_req
    logic [MBUS_CMD_WIDTH-1:0] cmd;
    assign cmd    = mbus_cmd_i[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
    // A port is masked during its ack cycle so a held command is not admitted twice.
    assign req[i] = (cmd == MBUS_CMD_WIDTH'(MbusWrBroad) ||
                     cmd == MBUS_CMD_WIDTH'(MbusRdBroad)) && !mbus_ack_q[i];
  end

  mesi_isc_rr_arb #(
    .NUM_CPU      (NUM_CPU),
    .CPU_ID_WIDTH (CPU_ID_WIDTH)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid)
  );

  // Fullness uses the registered count, so a same-cycle pop never frees a slot early.
  assign push         = gnt_valid && (count_q < CntW'(FIFO_DEPTH));
  assign gnt_cmd      = mbus_cmd_i[32'(gnt_idx)*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
  assign mbus_ack_d   = push ? gnt : '0;
  assign last_grant_d = push ? gnt_idx : last_grant_q;

  always_comb begin
    wr_entry        = '0;
    wr_entry.addr   = MaxAddrWidth'(mbus_addr_i[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH]);
    wr_entry.btype  = (gnt_cmd == MBUS_CMD_WIDTH'(MbusWrBroad)) ? BroadWr : BroadRd;
    wr_entry.cpu_id = MaxCpuIdWidth'(gnt_idx);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    head_d    = head_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          state_d   = StSnoop;
          head_d    = mem[rd_ptr_q];
          pending_d = '1;
          pending_d[CPU_ID_WIDTH'(head_d.cpu_id)] = 1'b0;
        end
      end
      StSnoop: begin
        pending_d = pending_q & ~cbus_ack_i;
        if (pending_d == '0) state_d = StEnable;
      end
      StEnable: begin
        if (cbus_ack_i[CPU_ID_WIDTH'(head_q.cpu_id)]) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are computed from next-state values so they can be registered.
    cbus_addr_d = '0;
    cbus_cmd_d  = '0;
    if (state_d != StIdle) cbus_addr_d = ADDR_WIDTH'(head_d.addr);
    for (int j = 0; j < NUM_CPU; j++) begin
      if (state_d == StSnoop && pending_d[j]) begin
        cbus_cmd_d[j*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
          CBUS_CMD_WIDTH'(snoop_cmd(head_d.btype));
      end else if (state_d == StEnable &&
                   CPU_ID_WIDTH'(head_d.cpu_id) == CPU_ID_WIDTH'(j)) begin
        cbus_cmd_d[j*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
          CBUS_CMD_WIDTH'(enable_cmd(head_d.btype));
      end
    end
  end

  assign wr_ptr_d = !push ? wr_ptr_q :
                    (wr_ptr_q == FIFO_DEPTH_LOG2'(FIFO_DEPTH - 1)) ? '0 :
                    wr_ptr_q + FIFO_DEPTH_LOG2'(1);
  assign rd_ptr_d = !pop ? rd_ptr_q :
                    (rd_ptr_q == FIFO_DEPTH_LOG2'(FIFO_DEPTH - 1)) ? '0 :
                    rd_ptr_q + FIFO_DEPTH_LOG2'(1);
  assign count_d  = count_q + CntW'(push) - CntW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      head_q       <= '0;
      pending_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= CPU_ID_WIDTH'(NUM_CPU - 1);
      mbus_ack_q   <= '0;
      cbus_addr_q  <= '0;
      cbus_cmd_q   <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      pending_q    <= pending_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      mbus_ack_q   <= mbus_ack_d;
      cbus_addr_q  <= cbus_addr_d;
      cbus_cmd_q   <= cbus_cmd_d;
    end
  end

  assign mbus_ack_o   = mbus_ack_q;
  assign cbus_addr_o  = cbus_addr_q;
  assign cbus_cmd_o   = cbus_cmd_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_mesi_isc_nport.sv
// Random-stimulus bench: a transaction-level model queues expected outputs per cycle,
// and a monitor pops and compares them against the interconnect.
module tb_mesi_isc_nport;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int MW    = 3;
  localparam int CW    = 3;
  localparam int DEPTH = 4;
  localparam int DL    = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N*MW-1:0] mbus_cmd = '0;
  logic [N*AW-1:0] mbus_addr = '0;
  logic [N-1:0]    cbus_ack = '0;
  logic [N-1:0]    mbus_ack;
  logic [AW-1:0]   cbus_addr;
  logic [N*CW-1:0] cbus_cmd;
  logic [DL:0]     fifo_count;

  mesi_isc_nport #(
    .NUM_CPU         (N),
    .CPU_ID_WIDTH    (2),
    .ADDR_WIDTH      (AW),
    .MBUS_CMD_WIDTH  (MW),
    .CBUS_CMD_WIDTH  (CW),
    .FIFO_DEPTH      (DEPTH),
    .FIFO_DEPTH_LOG2 (DL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mbus_cmd_i   (mbus_cmd),
    .mbus_addr_i  (mbus_addr),
    .cbus_ack_i   (cbus_ack),
    .mbus_ack_o   (mbus_ack),
    .cbus_addr_o  (cbus_addr),
    .cbus_cmd_o   (cbus_cmd),
    .fifo_count_o (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            origin;
    bit            wr;
    logic [AW-1:0] addr;
  } txn_t;

  typedef struct {
    logic [N-1:0]    ack;
    int              count;
    logic [AW-1:0]   addr;
    logic [N*CW-1:0] cmd;
  } obs_t;

  int total = 0;
  int bad   = 0;

  obs_t exp_q[$];
  txn_t queued[$];          // admitted transactions in order; head is the active one
  int           m_last  = N - 1;
  logic [N-1:0] m_ack   = '0;
  int           m_phase = 0;  // 0 idle, 1 snooping, 2 enabling originator
  logic [N-1:0] m_wait  = '0;
  txn_t         m_cur;
  int           m_done  = 0;

  bit            p_busy [N];
  logic [MW-1:0] p_cmd  [N];
  logic [AW-1:0] p_addr [N];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*CW-1:0] model_cmd();
    logic [N*CW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) begin
      if (m_phase == 1 && m_wait[j]) v[j*CW +: CW] = m_cur.wr ? 3'd1 : 3'd2;
      else if (m_phase == 2 && j == m_cur.origin) v[j*CW +: CW] = m_cur.wr ? 3'd3 : 3'd4;
    end
    return v;
  endfunction

  // Reference model: applies the rules for the cycle that just ended.
  always @(posedge clk) begin
    logic [N-1:0]  req;
    logic [MW-1:0] c;
    obs_t          o;
    int            g;
    #1;
    if (rst) begin
      queued.delete();
      m_last  = N - 1;
      m_ack   = '0;
      m_phase = 0;
      m_wait  = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        c      = mbus_cmd[i*MW +: MW];
        req[i] = (c == 3'd3 || c == 3'd4) && !m_ack[i];
      end
      g = -1;
      if (queued.size() < DEPTH) begin
        for (int k = 1; k <= N; k++) begin
          int p;
          p = (m_last + k) % N;
          if (g < 0 && req[p]) g = p;
        end
      end
      case (m_phase)
        0: if (queued.size() > 0) begin
          m_cur  = queued[0];
          m_wait = '1;
          m_wait[m_cur.origin] = 1'b0;
          m_phase = 1;
        end
        1: begin
          m_wait = m_wait & ~cbus_ack;
          if (m_wait == '0) m_phase = 2;
        end
        default: if (cbus_ack[m_cur.origin]) begin
          void'(queued.pop_front());
          m_phase = 0;
          m_done++;
        end
      endcase
      m_ack = '0;
      if (g >= 0) begin
        txn_t t;
        t.origin = g;
        t.wr     = (mbus_cmd[g*MW +: MW] == 3'd3);
        t.addr   = mbus_addr[g*AW +: AW];
        queued.push_back(t);
        m_ack[g] = 1'b1;
        m_last   = g;
      end
    end
    o.ack   = m_ack;
    o.count = queued.size();
    o.addr  = (m_phase != 0) ? m_cur.addr : '0;
    o.cmd   = model_cmd();
    exp_q.push_back(o);
  end

  always @(posedge clk) begin
    obs_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mbus_ack", 128'(mbus_ack), 128'(e.ack));
      check("fifo_count", 128'(fifo_count), 128'(e.count));
      check("cbus_addr", 128'(cbus_addr), 128'(e.addr));
      check("cbus_cmd", 128'(cbus_cmd), 128'(e.cmd));
    end
  end

  task automatic pack_inputs();
    for (int i = 0; i < N; i++) begin
      mbus_cmd[i*MW +: MW]  = p_cmd[i];
      mbus_addr[i*AW +: AW] = p_addr[i];
    end
  endtask

  task automatic drive_cycle(input int req_pct, input int ack_pct, input bit noise);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (m_ack[i]) p_busy[i] = 1'b0;
      if (!p_busy[i]) begin
        if (int'($urandom_range(99)) < req_pct) begin
          p_busy[i] = 1'b1;
          p_cmd[i]  = $urandom_range(1) ? 3'd3 : 3'd4;
          p_addr[i] = $urandom;
        end else begin
          p_cmd[i]  = noise ? MW'($urandom_range(2)) : 3'd0;
          p_addr[i] = $urandom;
        end
      end
      cbus_ack[i] = int'($urandom_range(99)) < ack_pct;
    end
    pack_inputs();
  endtask

  task automatic run(input int cycles, input int req_pct, input int ack_pct, input bit noise);
    for (int n = 0; n < cycles; n++) drive_cycle(req_pct, ack_pct, noise);
  endtask

  task automatic clear_ports();
    for (int i = 0; i < N; i++) begin
      p_busy[i] = 1'b0;
      p_cmd[i]  = '0;
      p_addr[i] = '0;
    end
    cbus_ack = '0;
    pack_inputs();
  endtask

  initial begin
    clear_ports();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single RD_BROAD from port 2 at 0x1000 with nothing else on the bus.
    p_busy[2] = 1'b1;
    p_cmd[2]  = 3'd4;
    p_addr[2] = 32'h1000;
    pack_inputs();
    run(40, 0, 50, 1'b0);

    run(1500, 30, 50, 1'b1);
    run(400, 60, 5, 1'b0);

    // Asynchronous reset with the FIFO backed up; outputs must clear before any edge.
    @(negedge clk);
    rst = 1'b1;
    clear_ports();
    #1;
    check("rst_mbus_ack", 128'(mbus_ack), 128'(0));
    check("rst_cbus_cmd", 128'(cbus_cmd), 128'(0));
    check("rst_cbus_addr", 128'(cbus_addr), 128'(0));
    check("rst_fifo_count", 128'(fifo_count), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run(1000, 40, 40, 1'b1);
    run(80, 0, 100, 1'b0);
    repeat (3) @(negedge clk);
    check("txns_completed", 128'(m_done > 50), 128'(1));
    check("scoreboard_drained", 128'(exp_q.size() <= 1), 128'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
